// File: rtl/row_fetcher_pkg.sv
// Shared constants and state encoding for the row fetcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the row/word geometry, the fetcher state encoding and the row base
// address helper used by row_address_gen.
package row_fetcher_pkg;

  localparam int ROW_BITS      = 640;
  localparam int WORD_BITS     = 16;
  localparam int ADDR_BITS     = 15;
  localparam int ROW_IDX_BITS  = 9;
  localparam int WORDS_PER_ROW = ROW_BITS / WORD_BITS;  // 40
  localparam int ROWS          = 480;
  localparam int WORD_CNT_BITS = $clog2(WORDS_PER_ROW);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    WRITE = 3'd4
  } fetchState_t;

  // Row r starts at word r*40; built from shifts, wraps modulo 2^ADDR_BITS.
  function automatic logic [ADDR_BITS-1:0] rowBase(input logic [ROW_IDX_BITS-1:0] row);
    logic [ADDR_BITS-1:0] r;
    r = ADDR_BITS'(row);
    return (r << 5) + (r << 3);
  endfunction

endpackage

// File: rtl/row_address_gen.sv
// Word counter plus row base adder producing the SRAM word address base+k.
// Latency: address is combinational from the counter; counter steps each edge.
// Backpressure: none; the caller decides when to load (reset to 0) or advance.
//
// Ports:
//   clkDiv, rst - clock and async active-low reset
//   row         - row index used for the base address
//   load        - force the word counter to 0 on the next edge (wins over advance)
//   advance     - step the word counter on the next edge
//   addr        - rowBase(row) + k
//   last        - high while k is the final word of the row (39)
module row_address_gen
  import row_fetcher_pkg::*;
(
  input  logic                    clkDiv,
  input  logic                    rst,
  input  logic [ROW_IDX_BITS-1:0] row,
  input  logic                    load,
  input  logic                    advance,
  output logic [ADDR_BITS-1:0]    addr,
  output logic                    last
);

  logic [WORD_CNT_BITS-1:0] wordCnt;

  always_ff @(posedge clkDiv or negedge rst) begin
    if (!rst) begin
      wordCnt <= '0;
    end else if (load) begin
      wordCnt <= '0;
    end else if (advance) begin
      wordCnt <= wordCnt + 1'b1;
    end
  end

  assign last = (wordCnt == WORD_CNT_BITS'(WORDS_PER_ROW - 1));
  assign addr = rowBase(row) + ADDR_BITS'(wordCnt);

endmodule

// File: rtl/row_fetcher.sv
// Fetches a 640-bit row from word-wide SRAM into readRow; optionally writes a row back.
// Latency: read 42 cycles start->idle (readRow updates at edge 41); write 40 cycles of memWe.
// Backpressure: none; start/commit seen while busy are dropped (bar one pending start).
//
// Optional feature macro: ROW_FETCH_WRITEBACK_EN (write-back path, shadow register,
// pending start). Without it, commit is ignored and memWe/memWdata stay 0.
//
// Ports:
//   clkDiv, rst            - sole clock, async active-low reset
//   start, rowIndex        - one-cycle fetch request for row rowIndex
//   commit, commitIndex    - one-cycle write-back request of writeRow to row commitIndex
//   writeRow               - row data to write back (copied at commit)
//   memRdata               - SRAM read data, valid one cycle after memRe
//   memAddr, memRe, memWe  - SRAM word address and strobes
//   memWdata               - SRAM write data
//   readRow                - last complete fetched row
//   reading                - one-cycle pulse when readRow updates
//   busy                   - high whenever not IDLE
module row_fetcher
  import row_fetcher_pkg::*;
(
  input  logic                    clkDiv,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ROW_IDX_BITS-1:0] rowIndex,
  input  logic                    commit,
  input  logic [ROW_IDX_BITS-1:0] commitIndex,
  input  logic [ROW_BITS-1:0]     writeRow,
  input  logic [WORD_BITS-1:0]    memRdata,
  output logic [ADDR_BITS-1:0]    memAddr,
  output logic                    memRe,
  output logic                    memWe,
  output logic [WORD_BITS-1:0]    memWdata,
  output logic [ROW_BITS-1:0]     readRow,
  output logic                    reading,
  output logic                    busy
);

  fetchState_t state, nextState;

  logic [ROW_IDX_BITS-1:0]       readIdx;
  logic [ROW_IDX_BITS-1:0]       addrRow;
  // Holds words 0..38; word 39 goes straight from memRdata into readRow.
  logic [ROW_BITS-WORD_BITS-1:0] staging;
  logic [ADDR_BITS-1:0]          wordAddr;
  logic                          wordLast;
  logic                          cntLoad;

`ifdef ROW_FETCH_WRITEBACK_EN
  logic [ROW_IDX_BITS-1:0] commitIdx;
  logic [ROW_BITS-1:0]     shadow;
  logic                    pendingStart;

  assign addrRow = (state == WRITE) ? commitIdx : readIdx;
`else
  logic unusedWriteback;

  assign unusedWriteback = ^{commit, commitIndex, writeRow};
  assign addrRow         = readIdx;
`endif

  // Counter sits at 0 outside the address phases and wraps to 0 at word 39,
  // so a WRITE->READ hand-off starts the read at word 0 with no idle cycle.
  assign cntLoad = !((state == READ) || (state == WRITE)) || wordLast;

  row_address_gen u_addrGen (
    .clkDiv  (clkDiv),
    .rst     (rst),
    .row     (addrRow),
    .load    (cntLoad),
    .advance (1'b1),
    .addr    (wordAddr),
    .last    (wordLast)
  );

  always_ff @(posedge clkDiv or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      readIdx <= '0;
      staging <= '0;
      readRow <= '0;
    end else begin
      state <= nextState;
      if ((state == IDLE) && start) begin
        readIdx <= rowIndex;
      end
      // Shifting from cycle 0 pushes one stale word in first; it falls off the
      // bottom by the time word 38 arrives, leaving words 0..38 in order.
      if (state == READ) begin
        staging <= {memRdata, staging[ROW_BITS-WORD_BITS-1:WORD_BITS]};
      end
      if (state == DRAIN) begin
        readRow <= {memRdata, staging};
      end
    end
  end

`ifdef ROW_FETCH_WRITEBACK_EN
  always_ff @(posedge clkDiv or negedge rst) begin
    if (!rst) begin
      commitIdx    <= '0;
      shadow       <= '0;
      pendingStart <= 1'b0;
    end else begin
      if ((state == IDLE) && commit) begin
        commitIdx    <= commitIndex;
        shadow       <= writeRow;
        pendingStart <= start;
      end else begin
        if (state == WRITE) begin
          shadow <= shadow >> WORD_BITS;
        end
        if (nextState == READ) begin
          pendingStart <= 1'b0;
        end
      end
    end
  end
`endif

  always_comb begin
    nextState = state;
    memRe     = 1'b0;
    memWe     = 1'b0;
    memAddr   = '0;
    memWdata  = '0;
    reading   = 1'b0;
    busy      = (state != IDLE);

    case (state)
      IDLE: begin
`ifdef ROW_FETCH_WRITEBACK_EN
        if (commit) begin
          nextState = WRITE;
        end else if (start) begin
          nextState = READ;
        end
`else
        if (start) begin
          nextState = READ;
        end
`endif
      end
      READ: begin
        memRe   = 1'b1;
        memAddr = wordAddr;
        if (wordLast) begin
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        nextState = DONE;
      end
      DONE: begin
        reading   = 1'b1;
`ifdef ROW_FETCH_WRITEBACK_EN
        nextState = pendingStart ? READ : IDLE;
`else
        nextState = IDLE;
`endif
      end
      WRITE: begin
`ifdef ROW_FETCH_WRITEBACK_EN
        memWe    = 1'b1;
        memAddr  = wordAddr;
        memWdata = shadow[WORD_BITS-1:0];
        if (wordLast) begin
          nextState = pendingStart ? READ : IDLE;
        end
`else
        nextState = IDLE;
`endif
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

endmodule
